uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- UART-to-memory bridge between a host serial link and the processor's single-port 16-bit block RAM.
- Receive mode: collects bytes from the rx line, packs byte pairs into 16-bit words and writes them to consecutive RAM addresses from 0.
- Send mode: reads consecutive RAM words from 0 and transmits each as two bytes on tx.
- Provides status (ready, clr, LEDs, state) to the processor control unit.

Parameters:
- CLKS_PER_BIT, 868, clk_100 cycles per UART bit (115200 baud at 100 MHz).
- NUM_WORDS, 1024, words transferred per receive or send session.
- ADDR_W, 16, RAM address width.

Ports:
- clk_100  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx  in  1  UART serial input, idle high
- tx  out  1  UART serial output, idle high
- data_in_io  in  16  RAM read data, one-cycle synchronous read latency
- data_out_io  out  16  RAM write data
- addr_io  out  16  RAM address
- we_io  out  1  RAM write enable, one-cycle pulse
- ctrl_io_receive  in  1  level: run receive session
- ctrl_io_send  in  1  level: run send session
- led_rx  out  1  high while in a receive session
- led_tx  out  1  high while in a send session
- ready  out  1  session complete flag
- clr  out  1  one-cycle pulse when a receive session completes (processor clear)
- state  out  6  current FSM state code
- send  out  1  high while the UART transmitter shifts a byte
- data_buffer  out  8  last byte received or transmitted

Behaviour:
- Reset: tx=1; data_out_io=0; addr_io=0; we_io=0; led_rx=0; led_tx=0; ready=0; clr=0; send=0; data_buffer=0; state=IDLE(0). Applies from any state, mid-frame included.
- rx path: passes through a 2-flop synchronizer before use.
- UART frame: 8N1, LSB first.
- RX sampling:
  - Falling edge starts a frame; start bit rechecked at CLKS_PER_BIT/2 and the frame aborts if rx is high there.
  - Data bits sampled every CLKS_PER_BIT thereafter, at bit centres.
  - Stop bit sampled; if 0 (framing error) the byte is discarded and the FSM returns to wait for the same byte slot.
- TX: start bit, 8 data bits, stop bit, each held CLKS_PER_BIT cycles; send=1 from start-bit begin to stop-bit end.
- FSM states and codes:
  - IDLE=0, RX_LO=1, RX_HI=2, RX_WR=3, RX_DONE=4
  - TX_RD=5, TX_WAIT=6, TX_LO=7, TX_HI=8, TX_NEXT=9, TX_DONE=10
- IDLE:
  - ctrl_io_receive=1 -> RX_LO with addr_io=0 and ready=0.
  - Otherwise ctrl_io_send=1 -> TX_RD with addr_io=0 and ready=0.
  - Receive has priority when both controls are high.
- Receive session:
  - RX_LO: first byte becomes word bits[7:0].
  - RX_HI: second byte becomes word bits[15:8].
  - RX_WR: drives data_out_io with the packed word and pulses we_io one cycle at addr_io.
  - If NUM_WORDS words have been written: go to RX_DONE, set ready=1, pulse clr one cycle.
  - Otherwise: addr_io+1, back to RX_LO.
  - Inter-byte gaps of any length are allowed.
- Send session:
  - TX_RD presents addr_io; TX_WAIT spends one cycle for RAM latency and latches data_in_io.
  - TX_LO sends bits[7:0]; TX_HI sends bits[15:8].
  - TX_NEXT: after NUM_WORDS words -> TX_DONE with ready=1; otherwise addr_io+1 -> TX_RD.
  - we_io stays 0 throughout.
- RX_DONE/TX_DONE: hold ready=1 until the corresponding ctrl input drops, then return to IDLE; ready stays 1 in IDLE until the next session starts.
- Control drop mid-session: the current byte finishes, then the FSM returns to IDLE with ready=0.
- data_buffer: updated on each completed received byte or each loaded transmit byte.
- addr_io: never exceeds NUM_WORDS-1; no wrap-around within a session.

Decomposition:
- Shared package: FSM state codes, default CLKS_PER_BIT, NUM_WORDS.
- One sub-module, uart_byte_phy: 8N1 rx and tx byte engines with the baud counter.
  - rx side: rx_valid/rx_byte.
  - tx side: tx_start/tx_byte/tx_busy.
- Top level holds the packing FSM and the RAM interface.

Test Plan:
- Setup for all scenarios: bench uses a behavioural RAM model with 1-cycle read latency and NUM_WORDS=2.
- Reset mid-frame: assert rst during an rx byte -> all outputs at reset values, state=0, tx=1.
- Receive, ctrl_io_receive=1: send bytes 0x0F, 0xF0 (short gap), long gap, then 0xCC, 0x18.
  - Required: we_io pulse at addr 0 with data 0xF00F.
  - Required: we_io pulse at addr 1 with data 0x18CC.
  - Required: ready=1, one clr pulse, data_buffer=0x18.
- Framing error: byte 0x55 with stop bit 0, then valid bytes 0x34, 0x12 -> only word 0x1234 written at addr 0; 0x55 dropped.
- Send, ctrl_io_send=1, RAM preloaded [0xF00F, 0x18CC]:
  - tx carries bytes 0x0F, 0xF0, 0xCC, 0x18, each 10 bits at CLKS_PER_BIT cycles/bit.
  - send high per byte; ready=1 at end; we_io never asserted.
- Both ctrl_io_receive and ctrl_io_send high from IDLE -> receive session entered (state=1, led_rx=1, led_tx=0).
- Glitch on rx: low pulse shorter than CLKS_PER_BIT/2 -> no byte accepted, state unchanged.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART-to-RAM loader: FSM state codes and
// default link/session parameters.
package uart_mem_loader_pkg;

  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int NUM_WORDS_DEF    = 1024;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'd0,
    ST_RX_LO   = 6'd1,
    ST_RX_HI   = 6'd2,
    ST_RX_WR   = 6'd3,
    ST_RX_DONE = 6'd4,
    ST_TX_RD   = 6'd5,
    ST_TX_WAIT = 6'd6,
    ST_TX_LO   = 6'd7,
    ST_TX_HI   = 6'd8,
    ST_TX_NEXT = 6'd9,
    ST_TX_DONE = 6'd10
  } state_t;

endpackage

// File: rtl/uart_mem_loader_phy.sv
// 8N1 byte engines with baud counters.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   rx_i                raw serial input (synchronised here)
//   rx_valid_o          one-cycle pulse: rx_byte_o holds a good byte
//   rx_byte_o           last received byte
//   rx_busy_o           a receive frame is in progress
//   tx_start_i          request to send tx_byte_i (ignored while busy)
//   tx_byte_i           byte to send
//   tx_busy_o           high from start-bit begin to stop-bit end
//   tx_o                serial output, idle high
module uart_byte_phy
  import uart_mem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_busy_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_byte_i,
  output logic       tx_busy_o,
  output logic       tx_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_st_t           rx_st_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic             rx_valid_q;
  logic [7:0]       rx_shift_q;

  logic             tx_q, tx_busy_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bits_q;
  logic [8:0]       tx_shift_q;

  // Synchroniser plus one extra flop for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_st_q)
        R_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_st_q  <= R_START;
          rx_cnt_q <= '0;
        end
        // Half-bit recheck rejects glitches shorter than half a bit.
        R_START: if (rx_cnt_q == HALF) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_sync_q ? R_IDLE : R_DATA;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        R_DATA: if (rx_cnt_q == FULL) begin
          rx_cnt_q <= '0;
          if (rx_bit_q == 3'd7) rx_st_q <= R_STOP;
          else rx_bit_q <= rx_bit_q + 1'b1;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        // A low stop bit is a framing error: the byte is never flagged.
        R_STOP: if (rx_cnt_q == FULL) begin
          rx_st_q    <= R_IDLE;
          rx_valid_q <= rx_sync_q;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_st_q == R_DATA && rx_cnt_q == FULL)
      rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
  end

  // tx_bits_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_cnt_q  <= '0;
      tx_bits_q <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start_i) begin
        tx_busy_q <= 1'b1;
        tx_q      <= 1'b0;
        tx_cnt_q  <= '0;
        tx_bits_q <= '0;
      end
    end else if (tx_cnt_q == FULL) begin
      tx_cnt_q <= '0;
      if (tx_bits_q == 4'd9) begin
        tx_busy_q <= 1'b0;
        tx_q      <= 1'b1;
      end else begin
        tx_q      <= tx_shift_q[0];
        tx_bits_q <= tx_bits_q + 1'b1;
      end
    end else begin
      tx_cnt_q <= tx_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!tx_busy_q && tx_start_i) tx_shift_q <= {1'b1, tx_byte_i};
    else if (tx_busy_q && tx_cnt_q == FULL) tx_shift_q <= {1'b1, tx_shift_q[8:1]};
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_byte_o  = rx_shift_q;
  assign rx_busy_o  = (rx_st_q != R_IDLE);
  assign tx_busy_o  = tx_busy_q;
  assign tx_o       = tx_q;

endmodule

// File: rtl/uart_mem_loader.sv
// UART-to-RAM bridge. Receive sessions pack byte pairs (low byte first) into
// 16-bit words written from address 0; send sessions read words from address 0
// and transmit each as low byte then high byte.
// Ports:
//   clk_100, rst                 clock, synchronous active-high reset
//   rx, tx                       UART serial lines, idle high
//   data_in_io                   RAM read data (one-cycle read latency)
//   data_out_io, addr_io, we_io  RAM write data, address, write strobe
//   ctrl_io_receive/_send        level requests for a session
//   led_rx, led_tx               session-active indicators
//   ready, clr                   session complete flag, receive-done pulse
//   state                        FSM state code
//   send                         transmitter shifting a byte
//   data_buffer                  last byte received or transmitted
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int NUM_WORDS    = NUM_WORDS_DEF,
  parameter int ADDR_W       = 16
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              rx,
  output logic              tx,
  input  logic [15:0]       data_in_io,
  output logic [15:0]       data_out_io,
  output logic [ADDR_W-1:0] addr_io,
  output logic              we_io,
  input  logic              ctrl_io_receive,
  input  logic              ctrl_io_send,
  output logic              led_rx,
  output logic              led_tx,
  output logic              ready,
  output logic              clr,
  output logic [5:0]        state,
  output logic              send,
  output logic [7:0]        data_buffer
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_out_q;
  logic              we_q, ready_q, clr_q, tx_start_q;
  logic [7:0]        buf_q, lo_q, hi_q, tx_byte_q;

  logic       rx_valid, rx_busy, tx_busy;
  logic [7:0] rx_byte;

  uart_byte_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk_i      (clk_100),
    .rst_i      (rst),
    .rx_i       (rx),
    .rx_valid_o (rx_valid),
    .rx_byte_o  (rx_byte),
    .rx_busy_o  (rx_busy),
    .tx_start_i (tx_start_q),
    .tx_byte_i  (tx_byte_q),
    .tx_busy_o  (tx_busy),
    .tx_o       (tx)
  );

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_out_q <= '0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      clr_q      <= 1'b0;
      buf_q      <= '0;
      tx_start_q <= 1'b0;
    end else begin
      we_q       <= 1'b0;
      clr_q      <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ctrl_io_receive) begin
            state_q <= ST_RX_LO;
            addr_q  <= '0;
            ready_q <= 1'b0;
          end else if (ctrl_io_send) begin
            state_q <= ST_TX_RD;
            addr_q  <= '0;
            ready_q <= 1'b0;
          end
        end
        // A dropped request is honoured only between bytes.
        ST_RX_LO: begin
          if (rx_valid) begin
            lo_q    <= rx_byte;
            buf_q   <= rx_byte;
            state_q <= ST_RX_HI;
          end else if (!ctrl_io_receive && !rx_busy) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RX_HI: begin
          if (rx_valid) begin
            data_out_q <= {rx_byte, lo_q};
            buf_q      <= rx_byte;
            we_q       <= 1'b1;
            state_q    <= ST_RX_WR;
          end else if (!ctrl_io_receive && !rx_busy) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RX_WR: begin
          if (addr_q == LAST) begin
            ready_q <= 1'b1;
            clr_q   <= 1'b1;
            state_q <= ST_RX_DONE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_RX_LO;
          end
        end
        ST_RX_DONE: if (!ctrl_io_receive) state_q <= ST_IDLE;
        ST_TX_RD: state_q <= ST_TX_WAIT;
        // RAM data is valid one cycle after the address was presented.
        ST_TX_WAIT: begin
          hi_q       <= data_in_io[15:8];
          tx_byte_q  <= data_in_io[7:0];
          buf_q      <= data_in_io[7:0];
          tx_start_q <= 1'b1;
          state_q    <= ST_TX_LO;
        end
        // tx_busy only rises the cycle after the start strobe, so skip that cycle.
        ST_TX_LO: begin
          if (!tx_start_q && !tx_busy) begin
            tx_byte_q  <= hi_q;
            buf_q      <= hi_q;
            tx_start_q <= 1'b1;
            state_q    <= ST_TX_HI;
          end
        end
        ST_TX_HI: if (!tx_start_q && !tx_busy) state_q <= ST_TX_NEXT;
        ST_TX_NEXT: begin
          if (addr_q == LAST) begin
            ready_q <= 1'b1;
            state_q <= ST_TX_DONE;
          end else if (!ctrl_io_send) begin
            state_q <= ST_IDLE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= ST_TX_RD;
          end
        end
        ST_TX_DONE: if (!ctrl_io_send) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out_io = data_out_q;
  assign addr_io     = addr_q;
  assign we_io       = we_q;
  assign ready       = ready_q;
  assign clr         = clr_q;
  assign state       = state_q;
  assign send        = tx_busy;
  assign data_buffer = buf_q;
  assign led_rx      = state_q inside {ST_RX_LO, ST_RX_HI, ST_RX_WR, ST_RX_DONE};
  assign led_tx      = state_q inside {ST_TX_RD, ST_TX_WAIT, ST_TX_LO, ST_TX_HI,
                                       ST_TX_NEXT, ST_TX_DONE};

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;

  localparam int CLKS = 16;
  localparam int NW   = 2;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        tx;
  logic [15:0] data_in_io;
  logic [15:0] data_out_io;
  logic [15:0] addr_io;
  logic        we_io;
  logic        ctrl_io_receive = 1'b0;
  logic        ctrl_io_send = 1'b0;
  logic        led_rx, led_tx, ready, clr, send;
  logic [5:0]  state;
  logic [7:0]  data_buffer;

  always #5 clk_100 = ~clk_100;

  uart_mem_loader #(.CLKS_PER_BIT(CLKS), .NUM_WORDS(NW), .ADDR_W(16)) dut (
    .clk_100(clk_100), .rst(rst), .rx(rx), .tx(tx),
    .data_in_io(data_in_io), .data_out_io(data_out_io), .addr_io(addr_io),
    .we_io(we_io), .ctrl_io_receive(ctrl_io_receive), .ctrl_io_send(ctrl_io_send),
    .led_rx(led_rx), .led_tx(led_tx), .ready(ready), .clr(clr), .state(state),
    .send(send), .data_buffer(data_buffer)
  );

  // Behavioural RAM, one-cycle read latency, with a bench preload port.
  logic [15:0] mem [0:NW-1];
  logic        pre_we = 1'b0;
  logic        pre_addr = 1'b0;
  logic [15:0] pre_data = '0;
  always @(posedge clk_100) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (we_io) mem[addr_io[0]] <= data_out_io;
    data_in_io <= mem[addr_io[0]];
  end

  int tests = 0, fails = 0;
  int clr_cnt = 0, we_cnt = 0, send_cnt = 0;

  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_bytes[$];
  logic       rx_stops[$];
  int         rx_gaps[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  // Write / clr / send monitor.
  initial begin
    wr_t e;
    logic send_prev;
    send_prev = 1'b0;
    forever begin
      @(negedge clk_100);
      if (we_io === 1'b1) begin
        we_cnt++;
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                   addr_io, data_out_io);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(addr_io), 32'(e.a));
          check("wr_data", 32'(data_out_io), 32'(e.d));
        end
      end
      if (clr === 1'b1) clr_cnt++;
      if (send === 1'b1 && !send_prev) send_cnt++;
      send_prev = (send === 1'b1);
    end
  end

  // Serial decoder on tx, sampling at bit centres.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (CLKS / 2) @(negedge clk_100);
      check("tx_start_bit", 32'(tx), 0);
      check("tx_send_high", 32'(send), 1);
      for (int i = 0; i < 8; i++) begin
        repeat (CLKS) @(negedge clk_100);
        b[i] = tx;
      end
      repeat (CLKS) @(negedge clk_100);
      check("tx_stop_bit", 32'(tx), 1);
      if (exp_tx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_tx_byte: got 0x%0h, no byte expected", b);
      end else begin
        check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
      end
    end
  end

  task automatic uart_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CLKS);
    end
    rx = stop;
    cyc(CLKS);
    rx = 1'b1;
  endtask

  // Reference: drop bytes with a bad stop bit, pair the rest low-then-high,
  // and write the first NW words to addresses 0..NW-1.
  task automatic model_rx(output logic [7:0] last_good);
    logic [7:0] good[$];
    last_good = data_buffer;
    for (int i = 0; i < rx_bytes.size(); i++)
      if (rx_stops[i]) good.push_back(rx_bytes[i]);
    for (int w = 0; w < NW && 2 * w + 1 < good.size(); w++)
      exp_wr.push_back('{a: 16'(w), d: {good[2*w+1], good[2*w]}});
    if (good.size() > 0) last_good = good[good.size()-1];
  endtask

  task automatic play_rx();
    for (int i = 0; i < rx_bytes.size(); i++) begin
      uart_byte(rx_bytes[i], rx_stops[i]);
      cyc(rx_gaps[i]);
    end
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    rx_stops.delete();
    rx_gaps.delete();
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      cyc(1);
      n++;
    end
    check("ready_reached", 32'(ready), 1);
  endtask

  task automatic preload(input logic a, input logic [15:0] d);
    @(negedge clk_100);
    pre_we = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(negedge clk_100);
    pre_we = 1'b0;
  endtask

  task automatic run_send(input logic [15:0] w0, input logic [15:0] w1);
    int sb, wb;
    preload(1'b0, w0);
    preload(1'b1, w1);
    exp_tx.push_back(w0[7:0]);
    exp_tx.push_back(w0[15:8]);
    exp_tx.push_back(w1[7:0]);
    exp_tx.push_back(w1[15:8]);
    sb = send_cnt;
    wb = we_cnt;
    ctrl_io_send = 1'b1;
    cyc(2);
    check("tx_led_tx", 32'(led_tx), 1);
    check("tx_led_rx", 32'(led_rx), 0);
    check("tx_ready_cleared", 32'(ready), 0);
    wait_ready(4 * 10 * CLKS + 400);
    cyc(CLKS);
    check("tx_done_state", 32'(state), 10);
    check("tx_send_pulses", 32'(send_cnt - sb), 4);
    check("tx_no_writes", 32'(we_cnt - wb), 0);
    check("tx_bytes_left", 32'(exp_tx.size()), 0);
    check("tx_data_buffer", 32'(data_buffer), 32'(w1[15:8]));
    ctrl_io_send = 1'b0;
    cyc(2);
    check("tx_back_idle", 32'(state), 0);
    check("tx_ready_held", 32'(ready), 1);
  endtask

  initial begin
    logic [7:0] last;
    int good, cb;
    logic [7:0] b0;

    // Reset values.
    cyc(5);
    check("rst_tx", 32'(tx), 1);
    check("rst_state", 32'(state), 0);
    check("rst_we", 32'(we_io), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_clr", 32'(clr), 0);
    check("rst_send", 32'(send), 0);
    check("rst_buf", 32'(data_buffer), 0);
    check("rst_addr", 32'(addr_io), 0);
    check("rst_dout", 32'(data_out_io), 0);
    check("rst_leds", 32'({led_rx, led_tx}), 0);
    rst = 1'b0;
    cyc(3);

    // Directed receive session with short and long inter-byte gaps.
    clear_rx();
    rx_bytes = '{8'h0F, 8'hF0, 8'hCC, 8'h18};
    rx_stops = '{1'b1, 1'b1, 1'b1, 1'b1};
    rx_gaps  = '{3, 500, 2, 5};
    model_rx(last);
    cb = clr_cnt;
    ctrl_io_receive = 1'b1;
    cyc(2);
    check("rx_state_entered", 32'(state), 1);
    check("rx_led_rx", 32'(led_rx), 1);
    play_rx();
    wait_ready(200);
    cyc(2);
    check("rx_done_state", 32'(state), 4);
    check("rx_clr_pulses", 32'(clr_cnt - cb), 1);
    check("rx_data_buffer", 32'(data_buffer), 32'(last));
    check("rx_writes_left", 32'(exp_wr.size()), 0);
    ctrl_io_receive = 1'b0;
    cyc(2);
    check("rx_back_idle", 32'(state), 0);
    check("rx_ready_held", 32'(ready), 1);

    // Reset in the middle of an rx frame.
    ctrl_io_receive = 1'b1;
    cyc(2);
    check("mid_rst_pre_state", 32'(state), 1);
    rx = 1'b0;
    cyc(CLKS * 3);
    rst = 1'b1;
    cyc(2);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_ready", 32'(ready), 0);
    check("mid_rst_buf", 32'(data_buffer), 0);
    check("mid_rst_addr", 32'(addr_io), 0);
    check("mid_rst_dout", 32'(data_out_io), 0);
    check("mid_rst_misc", 32'({we_io, clr, send, led_rx, led_tx}), 0);
    ctrl_io_receive = 1'b0;
    rx = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    check("mid_rst_after", 32'(state), 0);

    // Framing error: the bad byte is dropped, then abort by dropping control.
    clear_rx();
    rx_bytes = '{8'h55, 8'h34, 8'h12};
    rx_stops = '{1'b0, 1'b1, 1'b1};
    rx_gaps  = '{4, 4, 4};
    model_rx(last);
    ctrl_io_receive = 1'b1;
    play_rx();
    cyc(20);
    check("fe_state_waiting", 32'(state), 1);
    check("fe_data_buffer", 32'(data_buffer), 32'(last));
    check("fe_writes_left", 32'(exp_wr.size()), 0);
    ctrl_io_receive = 1'b0;
    cyc(3);
    check("fe_abort_idle", 32'(state), 0);
    check("fe_abort_ready", 32'(ready), 0);

    // Directed send session.
    run_send(16'hF00F, 16'h18CC);

    // Both requests high: receive wins.
    ctrl_io_receive = 1'b1;
    ctrl_io_send = 1'b1;
    cyc(3);
    check("both_state", 32'(state), 1);
    check("both_leds", 32'({led_rx, led_tx}), 32'(2'b10));
    ctrl_io_receive = 1'b0;
    ctrl_io_send = 1'b0;
    cyc(3);
    check("both_idle", 32'(state), 0);

    // Short rx glitch is not a start bit.
    ctrl_io_receive = 1'b1;
    cyc(3);
    b0 = data_buffer;
    rx = 1'b0;
    cyc(CLKS / 4);
    rx = 1'b1;
    cyc(CLKS * 12);
    check("glitch_state", 32'(state), 1);
    check("glitch_buf", 32'(data_buffer), 32'(b0));
    check("glitch_no_write", 32'(exp_wr.size()), 0);
    ctrl_io_receive = 1'b0;
    cyc(3);

    // Randomised sessions.
    for (int s = 0; s < 3; s++) begin
      clear_rx();
      good = 0;
      while (good < 2 * NW) begin
        rx_bytes.push_back(8'($urandom));
        rx_stops.push_back($urandom_range(0, 4) != 0);
        if (rx_stops[rx_stops.size()-1]) good++;
        rx_gaps.push_back($urandom_range(2, 60));
      end
      model_rx(last);
      ctrl_io_receive = 1'b1;
      play_rx();
      wait_ready(200);
      cyc(2);
      check("rnd_rx_buf", 32'(data_buffer), 32'(last));
      check("rnd_rx_writes_left", 32'(exp_wr.size()), 0);
      ctrl_io_receive = 1'b0;
      cyc(3);
      run_send(16'($urandom), 16'($urandom));
    end

    check("final_tx_left", 32'(exp_tx.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
